// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: controller states,
// slice width and the helper that sizes the nibble index.
package nsa_pkg;

   localparam int NIBBLE = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the nibble index; never narrower than one bit.
   function automatic int idx_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Requester-facing bundle of the nibble-serial adder.
// The sub signal exists only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
interface nibble_serial_adder_if #(
   parameter int WORDS = 4
);
   localparam int N = nsa_pkg::NIBBLE * WORDS;

   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [N-1:0] s;
   logic         cout;

   modport master (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      output sub,
`endif
      output start, a, b, cin,
      input  busy, done, s, cout
   );

   modport slave (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      input  start, a, b, cin,
      output busy, done, s, cout
   );

endinterface

// File: rtl/nibble_serial_adder_slice.sv
// Four-bit combinational ripple-carry adder built from full adders.
module nibble_slice (
   output logic [3:0] sum,
   output logic       co,
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci
);

   logic [4:0] c;

   // Ripple the carry through four full adders, LSB first.
   always_comb begin
      sum  = '0;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < 4; i++) begin
         sum[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
      co = c[4];
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit slice is reused over WORDS cycles,
// least-significant nibble first, with the carry held in a register.
// Optional subtract mode is enabled by NIBBLE_SERIAL_ADDER_SUB_EN.
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   nibble_serial_adder_if.slave bus
);

   localparam int IW = idx_w(WORDS);

   typedef logic [NIBBLE-1:0] nib_t;

   state_t              state_q;
   state_t              state_d;
   logic [IW-1:0]       idx_q;
   logic                carry_q;
   logic                cout_q;
   logic                cin_q;
   nib_t [WORDS-1:0]    a_q;
   nib_t [WORDS-1:0]    b_q;
   nib_t [WORDS-1:0]    s_q;

   logic                accept;
   logic                last;
   logic                inv_b;
   nib_t                x;
   nib_t                y;
   nib_t                sum;
   logic                ci;
   logic                co;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   logic                sub_q;
   assign inv_b = sub_q;
`else
   assign inv_b = 1'b0;
`endif

   // A start is only honoured while no operation is walking the nibbles.
   assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
   assign last   = (idx_q == IW'(WORDS - 1));

   // Subtraction is A + ~B + 1, so the forced carry replaces cin on nibble 0.
   assign x  = a_q[idx_q];
   assign y  = b_q[idx_q] ^ {NIBBLE{inv_b}};
   assign ci = (idx_q == '0) ? (inv_b | cin_q) : carry_q;

   nibble_slice u_slice (
      .sum (sum),
      .co  (co),
      .x   (x),
      .y   (y),
      .ci  (ci)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; DONE lasts exactly one cycle unless restarted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    state_d = bus.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Index, carry, result and carry-out; reset discards any partial work.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         idx_q   <= '0;
         s_q     <= '0;
      end else if (state_q == RUN) begin
         s_q[idx_q] <= sum;
         carry_q    <= co;
         idx_q      <= idx_q + 1'b1;
         if (last) cout_q <= co;
      end
   end

   // Operand capture; inputs are ignored for the rest of the operation.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         cin_q <= bus.cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
         sub_q <= bus.sub;
`endif
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.s    = s_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WORDS=4 main instance plus a
// WORDS=2 instance). Subtract cases run when NIBBLE_SERIAL_ADDER_SUB_EN is set.
`timescale 1ns/1ps
module tb_nibble_serial_adder;

   localparam int W  = 4;
   localparam int N  = 4 * W;
   localparam int W2 = 2;
   localparam int N2 = 4 * W2;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nibble_serial_adder_if #(.WORDS(W))  bus ();
   nibble_serial_adder_if #(.WORDS(W2)) bus2 ();

   nibble_serial_adder #(.WORDS(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   nibble_serial_adder #(.WORDS(W2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   typedef struct {
      logic [N-1:0] s;
      logic         cout;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: whole-word arithmetic, result modulo 2^N with carry in bit N.
   function automatic logic [N:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic cin, input logic sub);
      logic [N:0] r;
      if (sub) r = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
      else     r = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
      return r;
   endfunction

   // Monitor: pops one expectation per done pulse.
   initial begin
      exp_t e;
      int   busy_cnt;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            busy_cnt = 0;
         end else begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
               if (sb.size() == 0) begin
                  check("done_without_request", bus.done, 1'b0);
               end else begin
                  e = sb.pop_front();
                  check("sum", bus.s, e.s);
                  check("cout", bus.cout, e.cout);
                  check("latency", cyc - e.acc, W);
                  check("busy_cycles", busy_cnt, W);
               end
               busy_cnt = 0;
            end
         end
      end
   end

   // Issue one operation; must be called just after a falling edge.
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic sub);
      exp_t       e;
      logic [N:0] r;
      int         guard;
      guard = 0;
      while (bus.busy === 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (bus.busy !== 1'b0) check("idle_wait", bus.busy, 1'b0);
      bus.a   = a;
      bus.b   = b;
      bus.cin = cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      bus.sub = sub;
`endif
      bus.start = 1'b1;
      r      = ref_op(a, b, cin, sub & HAS_SUB);
      e.s    = r[N-1:0];
      e.cout = r[N];
      e.acc  = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Wait for done while scrambling the (latched) inputs.
   task automatic wait_done(output int t);
      int k;
      k = 0;
      while (k < 50) begin
         @(negedge clk);
         bus.a   = N'($urandom);
         bus.b   = N'($urandom);
         bus.cin = 1'($urandom);
         if (bus.done === 1'b1) break;
         k++;
      end
      if (bus.done !== 1'b1) check("done_timeout", bus.done, 1'b1);
      t = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          t1, t2, k;
      logic [N-1:0] ra, rb;
      logic [N2-1:0] a2 [4];
      logic [N2-1:0] b2 [4];
      logic [N2:0]   r2;

      rst        = 1'b1;
      bus.start  = 1'b0; bus.a  = '0; bus.b  = '0; bus.cin  = 1'b0;
      bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      bus.sub = 1'b0; bus2.sub = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("reset_s", bus.s, 0);
      check("reset_cout", bus.cout, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      rst = 1'b0;
      @(negedge clk);

      // Full carry ripple.
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_done(t1);
      do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0); wait_done(t1);

      // Reset after two RUN cycles; cout is 1 from the previous result.
      do_op(16'h7777, 16'h1111, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrun_rst_s", bus.s, 0);
      check("midrun_rst_cout", bus.cout, 0);
      check("midrun_rst_busy", bus.busy, 0);
      check("midrun_rst_done", bus.done, 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      // Plain add.
      do_op(16'h1234, 16'h4321, 1'b0, 1'b0); wait_done(t1);

      // Start pulse during RUN is ignored, then a back-to-back start in DONE.
      do_op(16'h0102, 16'h0304, 1'b1, 1'b0);
      @(negedge clk);
      bus.a = 16'hAAAA; bus.b = 16'h5555; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(t1);
      do_op(16'h0001, 16'h0002, 1'b0, 1'b0);
      wait_done(t2);
      check("b2b_spacing", t2 - t1, W + 1);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1); wait_done(t1);
      do_op(16'h0007, 16'h0005, 1'b1, 1'b1); wait_done(t1);
`endif

      // Randomised operations with occasional extreme operands and gaps.
      for (int i = 0; i < 40; i++) begin
         k  = $urandom_range(0, 5);
         ra = (k == 0) ? 16'hFFFF : N'($urandom);
         rb = (k == 1) ? 16'hFFFF : ((k == 2) ? 16'h0000 : N'($urandom));
         do_op(ra, rb, 1'($urandom), 1'($urandom));
         wait_done(t1);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      // WORDS=2 instance: directed case then random ones.
      a2[0] = 8'hF0; b2[0] = 8'h10;
      for (int i = 1; i < 4; i++) begin
         a2[i] = 8'($urandom);
         b2[i] = 8'($urandom);
      end
      for (int i = 0; i < 4; i++) begin
         bus2.a = a2[i]; bus2.b = b2[i]; bus2.cin = 1'b0; bus2.start = 1'b1;
         t1 = cyc + 1;
         @(negedge clk);
         bus2.start = 1'b0;
         k = 0;
         while (bus2.done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
         end
         r2 = {1'b0, a2[i]} + {1'b0, b2[i]};
         check("w2_latency", cyc - t1, W2);
         check("w2_sum", bus2.s, r2[N2-1:0]);
         check("w2_cout", bus2.cout, r2[N2]);
         @(negedge clk);
      end

      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("scoreboard_drain", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential controller that performs a WORDS×4-bit addition by time-multiplexing one 4-bit ripple-carry adder slice over WORDS cycles, least-significant nibble first. A requester issues a start pulse with full-width operands; the block latches them, walks the nibbles, and holds the registered carry between cycles. It then presents the sum, carry-out and a one-cycle done pulse. It sits between any wide-operand requester and the existing nibble-adder datapath, so wide adds reuse the single 4-bit slice.

## Interface
- WORDS, 4, number of nibbles per operand; legal range 2..16; operand width N = 4*WORDS
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  N  operand A; latched on an accepted start
- b  input  N  operand B; latched on an accepted start
- cin  input  1  carry-in to nibble 0; latched on an accepted start
- sub  input  1  subtract request; present only with SUB_EN
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on entry to DONE
- s  output  N  result; registered and held until the next accepted start
- cout  output  1  carry out of the top nibble; registered and held

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches a, b and cin, clears s, sets idx=0, and moves to RUN. start=0 stays in IDLE.
- RUN: each cycle feeds nibble idx of A and B, plus the carry register, to the slice.
  - The sum nibble is written into s[4*idx+3:4*idx].
  - The carry register takes the slice carry-out.
  - idx increments.
  - When idx = WORDS-1: cout takes the slice carry-out and the state moves to DONE.
- DONE: done=1 for this single cycle.
  - start=1 is accepted exactly as in IDLE, giving back-to-back operation.
  - Otherwise the state moves to IDLE.
- start in RUN is ignored; there is no queueing. Input changes during RUN have no effect because the operands are latched.
- Arithmetic is modulo 2^N. For nibble 0 the carry-in is the latched cin; for every later nibble it is the carry register.
- Reset, asynchronous at any time including mid-RUN:
  - state=IDLE, idx=0, carry register=0, s=0, cout=0, busy=0, done=0.
  - Any in-flight operation is discarded and no done is produced.

## Timing
- Define edge E0 as the edge that accepts start.
- Nibbles k = 0..WORDS-1 are computed on edges E1..E_WORDS.
- done, final s and cout are visible after edge E_WORDS. Latency is WORDS cycles from acceptance.
- busy is high from after E0 until E_WORDS.
- Partial s is visible during RUN; it is valid only when done=1 or in the IDLE that follows.
- Throughput with back-to-back starts: one operation per WORDS+1 cycles.
- The slice is purely combinational. The only registers are state, idx, the carry register, the latched operands, s and cout.

## Configuration
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined:
  - The sub port exists and is latched on start.
  - When sub=1, every B nibble is inverted before the slice and the nibble-0 carry-in is forced to 1; cin is ignored.
  - cout=1 means no borrow.
- Undefined: the sub port is absent, and the block only adds.

## Structure
- Shared package nsa_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the NIBBLE=4 constant
  - the function computing the idx width, $clog2(WORDS)
- One sub-module, nibble_slice: a 4-bit combinational ripple-carry adder built from full adders, with ports (sum[3:0], co, x[3:0], y[3:0], ci).
- The controller instantiates nibble_slice exactly once.

## Test plan
All cases use WORDS=4 unless stated.
- Add: start with a=0x1234, b=0x4321, cin=0 -> done after exactly 4 cycles; s=0x5555, cout=0; busy high for 4 cycles.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1.
- Start ignored during RUN, then back-to-back:
  - Pulse start with new operands 2 cycles into RUN -> first result unaffected and no extra done.
  - Then start held high in DONE with a=0x0001, b=0x0002 -> second done 5 cycles after the first; s=0x0003.
- Reset mid-operation: assert rst after 2 RUN cycles -> s=0, cout=0, busy=0 immediately; no done; the next start completes normally.
- With NIBBLE_SERIAL_ADDER_SUB_EN:
  - sub=1, a=0x0005, b=0x0007 -> s=0xFFFE, cout=0.
  - sub=1, a=0x0007, b=0x0005 -> s=0x0002, cout=1.
- WORDS=2: a=0xF0, b=0x10 -> done after 2 cycles; s=0x00, cout=1.
